// File: rtl/md_unit_if.sv
// Bus between the E-stage pipeline and the HI/LO multiply/divide unit.
// The pipeline (master) issues operations. The unit (slave) reports busy and the architectural HI/LO values.
interface md_unit_if;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, md_op, rs_val, rt_val,
    input  busy, hi, lo
  );

  modport slave (
    input  start, md_op, rs_val, rt_val,
    output busy, hi, lo
  );
endinterface

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers for the E stage.
// The result is computed and latched at the accepting edge. The unit then
// counts out the modelled latency and commits to HI/LO at the final edge.
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input logic      clk,
  input logic      reset,
  md_unit_if.slave bus
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]  state;
  logic [31:0] cnt;
  logic [31:0] hi_reg;
  logic [31:0] lo_reg;
  logic [31:0] res_hi;
  logic [31:0] res_lo;
  logic        commit;

  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;
  logic [31:0] abs_rs;
  logic [31:0] abs_rt;
  logic [31:0] sdiv_by;
  logic [31:0] udiv_by;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] q_s;
  logic [31:0] r_s;
  logic [31:0] q_u;
  logic [31:0] r_u;

  assign bus.busy = (state == RUN);
  assign bus.hi   = hi_reg;
  assign bus.lo   = lo_reg;

  assign prod_s = $signed({{32{bus.rs_val[31]}}, bus.rs_val}) *
                  $signed({{32{bus.rt_val[31]}}, bus.rt_val});
  assign prod_u = {32'd0, bus.rs_val} * {32'd0, bus.rt_val};

  // Signed divide is done on magnitudes so that 0x80000000 / -1 wraps cleanly.
  // A zero divisor is replaced by 1 so the divider never sees zero. That result is never committed.
  always_comb begin
    abs_rs  = bus.rs_val[31] ? (~bus.rs_val + 32'd1) : bus.rs_val;
    abs_rt  = bus.rt_val[31] ? (~bus.rt_val + 32'd1) : bus.rt_val;
    sdiv_by = (abs_rt == 32'd0) ? 32'd1 : abs_rt;
    udiv_by = (bus.rt_val == 32'd0) ? 32'd1 : bus.rt_val;
    q_mag   = abs_rs / sdiv_by;
    r_mag   = abs_rs % sdiv_by;
    q_s     = (bus.rs_val[31] ^ bus.rt_val[31]) ? (~q_mag + 32'd1) : q_mag;
    r_s     = bus.rs_val[31] ? (~r_mag + 32'd1) : r_mag;
    q_u     = bus.rs_val / udiv_by;
    r_u     = bus.rs_val % udiv_by;
  end

  // Sequencer: accept in IDLE, count down in RUN, commit the latched result on the last edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= IDLE;
      cnt    <= '0;
      hi_reg <= '0;
      lo_reg <= '0;
      res_hi <= '0;
      res_lo <= '0;
      commit <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            case (bus.md_op)
              3'd0: begin
                res_hi <= prod_s[63:32];
                res_lo <= prod_s[31:0];
                commit <= 1'b1;
                cnt    <= 32'(MULT_CYCLES - 1);
                state  <= RUN;
              end
              3'd1: begin
                res_hi <= prod_u[63:32];
                res_lo <= prod_u[31:0];
                commit <= 1'b1;
                cnt    <= 32'(MULT_CYCLES - 1);
                state  <= RUN;
              end
              3'd2: begin
                res_hi <= r_s;
                res_lo <= q_s;
                commit <= (bus.rt_val != 32'd0);
                cnt    <= 32'(DIV_CYCLES - 1);
                state  <= RUN;
              end
              3'd3: begin
                res_hi <= r_u;
                res_lo <= q_u;
                commit <= (bus.rt_val != 32'd0);
                cnt    <= 32'(DIV_CYCLES - 1);
                state  <= RUN;
              end
              3'd4:    hi_reg <= bus.rs_val;
              3'd5:    lo_reg <= bus.rs_val;
              default: ;
            endcase
          end
        end
        RUN: begin
          if (cnt == 32'd0) begin
            if (commit) begin
              hi_reg <= res_hi;
              lo_reg <= res_lo;
            end
            state <= IDLE;
          end else begin
            cnt <= cnt - 32'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed timing and corner cases, then random ops against a reference model.
module tb_md_unit;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;
  logic [31:0] m_hi;
  logic [31:0] m_lo;

  md_unit_if bus ();

  md_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Safety net against a hung run
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one start pulse at a negedge. It returns at the next negedge with the operands scrambled.
  task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.start  = 1'b1;
    bus.md_op  = op;
    bus.rs_val = a;
    bus.rt_val = b;
    @(negedge clk);
    bus.start  = 1'b0;
    bus.md_op  = 3'($urandom_range(0, 7));
    bus.rs_val = $urandom;
    bus.rt_val = $urandom;
  endtask

  task automatic waitBusy(output int n);
    n = 0;
    while (bus.busy === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic runOp(input string tag, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp_hi,
                       input logic [31:0] exp_lo, input int exp_n);
    int n;
    applyStimulus(op, a, b);
    waitBusy(n);
    checkOutput({tag, "_busy_cycles"}, 64'(n), 64'(exp_n));
    checkOutput({tag, "_hi"}, {32'd0, bus.hi}, {32'd0, exp_hi});
    checkOutput({tag, "_lo"}, {32'd0, bus.lo}, {32'd0, exp_lo});
  endtask

  // Reference model: architectural effect of one op on {hi,lo}
  function automatic logic [63:0] modelOp(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [31:0] ch,
                                          input logic [31:0] cl);
    longint x, y, q, r;
    logic [63:0] p;
    case (op)
      3'd0: begin
        p = 64'(longint'($signed(a)) * longint'($signed(b)));
        return p;
      end
      3'd1: begin
        p = {32'd0, a} * {32'd0, b};
        return p;
      end
      3'd2: begin
        if (b == 32'd0) return {ch, cl};
        x = longint'($signed(a));
        y = longint'($signed(b));
        q = x / y;
        r = x % y;
        return {r[31:0], q[31:0]};
      end
      3'd3: begin
        if (b == 32'd0) return {ch, cl};
        x = longint'({32'd0, a});
        y = longint'({32'd0, b});
        q = x / y;
        r = x % y;
        return {r[31:0], q[31:0]};
      end
      3'd4:    return {a, cl};
      3'd5:    return {ch, a};
      default: return {ch, cl};
    endcase
  endfunction

  function automatic int latencyOf(input logic [2:0] op);
    if (op <= 3'd1) return MULT_N;
    if (op <= 3'd3) return DIV_N;
    return 0;
  endfunction

  initial begin
    int n;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic [63:0] r;

    vectors     = 0;
    miscompares = 0;

    // Reset held with a live mult request
    reset      = 1'b0;
    bus.start  = 1'b1;
    bus.md_op  = 3'd0;
    bus.rs_val = 32'h1234_5678;
    bus.rt_val = 32'h0000_0003;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checkOutput("reset_busy", {63'd0, bus.busy}, 64'd0);
      checkOutput("reset_hi", {32'd0, bus.hi}, 64'd0);
      checkOutput("reset_lo", {32'd0, bus.lo}, 64'd0);
    end
    reset     = 1'b1;
    bus.start = 1'b0;
    @(negedge clk);
    checkOutput("post_reset_busy", {63'd0, bus.busy}, 64'd0);
    checkOutput("post_reset_hi", {32'd0, bus.hi}, 64'd0);
    checkOutput("post_reset_lo", {32'd0, bus.lo}, 64'd0);

    // Multiply timing and signedness
    runOp("mult", 3'd0, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MULT_N);
    runOp("multu", 3'd1, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 32'hFFFF_FFFE, MULT_N);

    // Divide signs and overflow
    runOp("div_neg", 3'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, DIV_N);
    runOp("divu", 3'd3, 32'd7, 32'd2, 32'd1, 32'd3, DIV_N);
    runOp("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, DIV_N);

    // Divide by zero leaves preloaded HI/LO
    runOp("mthi", 3'd4, 32'h11, 32'd0, 32'h11, 32'h8000_0000, 0);
    runOp("mtlo", 3'd5, 32'h22, 32'd0, 32'h11, 32'h22, 0);
    runOp("divu_zero", 3'd3, 32'd5, 32'd0, 32'h11, 32'h22, DIV_N);

    // mtlo pulsed while busy is ignored
    applyStimulus(3'd0, 32'h1234, 32'h10);
    bus.start  = 1'b1;
    bus.md_op  = 3'd5;
    bus.rs_val = 32'hAA;
    @(negedge clk);
    bus.start = 1'b0;
    waitBusy(n);
    checkOutput("ignored_busy_cycles", 64'(n), 64'(MULT_N - 1));
    checkOutput("ignored_hi", {32'd0, bus.hi}, 64'd0);
    checkOutput("ignored_lo", {32'd0, bus.lo}, 64'h12340);
    @(negedge clk);
    checkOutput("ignored_lo_later", {32'd0, bus.lo}, 64'h12340);

    // Reset during the third busy cycle aborts the mult
    applyStimulus(3'd0, 32'h7, 32'h9);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("abort_busy", {63'd0, bus.busy}, 64'd0);
    checkOutput("abort_hi", {32'd0, bus.hi}, 64'd0);
    checkOutput("abort_lo", {32'd0, bus.lo}, 64'd0);
    reset = 1'b1;
    for (int i = 0; i < 8; i++) @(negedge clk);
    checkOutput("abort_busy_later", {63'd0, bus.busy}, 64'd0);
    checkOutput("abort_hi_later", {32'd0, bus.hi}, 64'd0);
    checkOutput("abort_lo_later", {32'd0, bus.lo}, 64'd0);

    // Back-to-back: second op issued in the cycle right after busy drops
    runOp("b2b_mult", 3'd0, 32'd3, 32'd4, 32'd0, 32'd12, MULT_N);
    runOp("b2b_divu", 3'd3, 32'd100, 32'd7, 32'd2, 32'd14, DIV_N);

    // Random ops against the reference model
    m_hi = 32'd2;
    m_lo = 32'd14;
    for (int k = 0; k < 60; k++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 9) == 0) begin
        a = 32'h8000_0000;
        b = 32'hFFFF_FFFF;
      end
      if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(1, 20));
      r = modelOp(op, a, b, m_hi, m_lo);
      runOp($sformatf("rand%0d_op%0d", k, op), op, a, b, r[63:32], r[31:0], latencyOf(op));
      m_hi = r[63:32];
      m_lo = r[31:0];
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/md_unit.md
# md_unit

Multi-cycle multiply/divide unit with HI/LO registers, sitting in the E stage beside the ALU of the 5-stage MIPS pipeline. It accepts mult/multu/div/divu/mthi/mtlo from the D_E register and models real multiply/divide latency. It raises `busy` so the D-stage hazard logic can stall any HI/LO-dependent instruction. HI/LO values are read by mfhi/mflo in E and forwarded like an ALU result.

## Interface
- `MULT_CYCLES`, default 5: cycles `busy` stays high for mult/multu (≥1).
- `DIV_CYCLES`, default 10: cycles `busy` stays high for div/divu (≥1).

Ports:
- `clk`  in  1  pipeline clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-low. `reset==0` at an edge clears all state.
- `start`  in  1  qualifies `md_op` this cycle. It is high for one cycle per E-stage md instruction.
- `md_op`  in  3  operation code:
  - 0: mult
  - 1: multu
  - 2: div
  - 3: divu
  - 4: mthi
  - 5: mtlo
  - 6–7: no-op
- `rs_val`  in  32  forwarded rs operand (dividend / multiplicand / mthi/mtlo source).
- `rt_val`  in  32  forwarded rt operand (divisor / multiplier).
- `busy`  out  1  registered; high while an operation is in flight.
- `hi`  out  32  architectural HI register.
- `lo`  out  32  architectural LO register.

## Operation
States:
- IDLE: `busy=0`.
  - `start` with op 0/1 loads `cnt=MULT_CYCLES-1`, latches the result into `res_hi/res_lo`, and goes to RUN.
  - `start` with op 2/3 does the same with `cnt=DIV_CYCLES-1`.
  - `start` with op 4/5 writes `rs_val` into `hi`/`lo` at that edge and stays in IDLE.
  - `start` with op 6/7 does nothing.
- RUN: `busy=1`. `cnt` decrements each edge.
  - At the edge where `cnt==0`: `hi<=res_hi`, `lo<=res_lo`, `busy<=0`, go to IDLE.
  - `start` during RUN is ignored entirely, including mthi/mtlo. The pipeline guarantees this never happens by stalling on `busy`; the verifier checks that it is ignored.

Arithmetic:
- mult: signed 32×32→64, `{hi,lo}` = product.
- multu: the same, unsigned.
- div: signed.
  - `lo` = quotient truncated toward zero.
  - `hi` = remainder, with the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives `lo`=0x80000000, `hi`=0.
- divu: unsigned quotient and remainder.
- Divide by zero (`rt_val==0`, div or divu): the unit still runs DIV_CYCLES with `busy`, then leaves `hi`/`lo` unchanged (no commit).
- Operands are sampled only at the accepting edge. Later changes on `rs_val`/`rt_val` have no effect.

Reset:
- `hi=0`, `lo=0`, `busy=0`, state IDLE, `cnt=0`.
- Reset asserted mid-RUN aborts the operation with no commit.
- Reset takes priority over a commit in the same cycle.

Hazard contract for the D stage: the stall condition for mfhi/mflo/mult/div/mthi/mtlo in D is `busy | (start & md_op<=3)`.

## Timing
- Accept at edge T (`start=1` sampled, op 0–3).
  - `busy`=1 during cycles T+1 … T+N, where N=MULT_CYCLES or DIV_CYCLES.
  - `hi`/`lo` take new values after edge T+N.
  - `busy`=0 after edge T+N.
- A new `start` sampled at edge T+N+1 is accepted. Back-to-back operations therefore have one IDLE cycle between them.
- mthi/mtlo: the write becomes visible after edge T, 1-cycle latency, `busy` never rises.
- `hi`/`lo` are register outputs with no combinational path from the inputs.

## Test plan
1. **Reset.** Hold `reset=0` for 2 cycles with `start=1, md_op=0`. Required: `hi=0`, `lo=0`, `busy=0` throughout and after release.
2. **mult timing.** mult `rs=0xFFFFFFFF`, `rt=2` at edge T. Required: `busy` high for exactly 5 cycles; then `hi=0xFFFFFFFF`, `lo=0xFFFFFFFE`. The same operands with multu give `hi=1`, `lo=0xFFFFFFFE`.
3. **div signs and overflow.**
   - div `rs=-7` (0xFFFFFFF9), `rt=2`. Required: `busy` for 10 cycles; `lo=0xFFFFFFFD`, `hi=0xFFFFFFFF`.
   - divu 7/2. Required: `lo=3`, `hi=1`.
   - div 0x80000000/0xFFFFFFFF. Required: `lo=0x80000000`, `hi=0`.
4. **Divide by zero.** Preload `hi=0x11`, `lo=0x22` via mthi/mtlo, then divu 5/0. Required: `busy` for 10 cycles, then `hi=0x11`, `lo=0x22`.
5. **Ignored start and abort.**
   - Start mult, then pulse `start` with mtlo `rs=0xAA` while `busy`. Required: the mult result commits and `lo` is not 0xAA.
   - Repeat the mult and assert reset at the 3rd busy cycle. Required: `hi=lo=0`, `busy=0`, and no commit afterwards.
6. **Back-to-back.** mult 3×4 accepted at edge T, then divu 100/7 issued at T+6. Required: `lo=12`, `hi=0` after edge T+5; then `lo=14`, `hi=2` after edge T+16.
